// File: rtl/brus16_gpu_pkg.sv
// Shared GPU-side constants and types: palette geometry, bus widths,
// the palette-DMA state encoding and its I/O trigger register offset.
package brus16_gpu_pkg;

  localparam int ADDR_W      = 13;
  localparam int PAL_AW      = 6;
  localparam int DATA_W      = 16;
  localparam int PAL_ENTRIES = 1 << PAL_AW;

  // CPU I/O register offset whose write pulses the palette-DMA start.
  localparam logic [7:0] IO_PAL_DMA_TRIG = 8'h30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    XFER    = 2'd2
  } pdma_state_t;

endpackage

// File: rtl/palette_dma_if.sv
// Buses of the palette DMA: data-RAM read port (secondary requester) and
// the colours-BRAM port-A write side. master = DMA, slave = RAM/BRAM side.
interface palette_dma_if #(
  parameter int ADDR_W = brus16_gpu_pkg::ADDR_W,
  parameter int PAL_AW = brus16_gpu_pkg::PAL_AW,
  parameter int DATA_W = brus16_gpu_pkg::DATA_W
);

  // A read is issued in any cycle with mem_req && mem_gnt; mem_rdata is
  // valid exactly one cycle later. There is no back-pressure on pal_*.
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              pal_cea;
  logic [PAL_AW-1:0] pal_ada;
  logic [DATA_W-1:0] pal_din;

  modport master (
    output mem_req, mem_addr, pal_cea, pal_ada, pal_din,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, pal_cea, pal_ada, pal_din,
    output mem_gnt, mem_rdata
  );

endinterface

// File: rtl/palette_dma.sv
// Copies the 64-entry palette from data RAM into colours-BRAM port A, only
// during vblank. Optional start queueing: PALETTE_DMA_QUEUE_EN.
module palette_dma #(
  parameter int ADDR_W = brus16_gpu_pkg::ADDR_W,
  parameter int PAL_AW = brus16_gpu_pkg::PAL_AW,
  parameter int DATA_W = brus16_gpu_pkg::DATA_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic                         vblank,
  palette_dma_if.master                bus,
  output logic                         busy,
  output logic                         done,
  output brus16_gpu_pkg::pdma_state_t  state
);

  localparam int CNT_W = PAL_AW + 1;
  localparam logic [CNT_W-1:0] ENTRIES  = CNT_W'(1 << PAL_AW);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << PAL_AW) - 1);

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  wr_idx;
  logic              inflight;
  logic [PAL_AW-1:0] inflight_idx;
  logic              mem_req;
  logic              issue;
  logic              accept;

`ifdef PALETTE_DMA_QUEUE_EN
  logic              pending;
  logic [ADDR_W-1:0] pending_base;
`endif

  // mem_req follows vblank combinationally so a falling vblank stops reads
  // in the very same cycle.
  assign mem_req = (state == brus16_gpu_pkg::XFER) && (rd_idx < ENTRIES) && vblank;
  assign issue   = mem_req && bus.mem_gnt;
  assign done    = inflight && (wr_idx == LAST_IDX);
  assign accept  = start && (!busy || done);

  // The write lands in the cycle the read data arrives; no data register.
  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = mem_req ? base_q + ADDR_W'(rd_idx) : '0;
  assign bus.pal_cea  = inflight;
  assign bus.pal_ada  = inflight ? inflight_idx : '0;
  assign bus.pal_din  = inflight ? bus.mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= brus16_gpu_pkg::IDLE;
      base_q       <= '0;
      rd_idx       <= '0;
      wr_idx       <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      busy         <= 1'b0;
`ifdef PALETTE_DMA_QUEUE_EN
      pending      <= 1'b0;
      pending_base <= '0;
`endif
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_idx <= rd_idx[PAL_AW-1:0];
        rd_idx       <= rd_idx + 1'b1;
      end
      if (inflight) begin
        wr_idx <= wr_idx + 1'b1;
      end

      case (state)
        brus16_gpu_pkg::WAIT_VB: if (vblank)  state <= brus16_gpu_pkg::XFER;
        brus16_gpu_pkg::XFER:    if (!vblank) state <= brus16_gpu_pkg::WAIT_VB;
        default: ;
      endcase

      // Completion and (re)start override the stepping above; a start in
      // the done cycle chains straight into a new transfer.
      if (accept) begin
        base_q <= base_addr;
        rd_idx <= '0;
        wr_idx <= '0;
        busy   <= 1'b1;
        state  <= brus16_gpu_pkg::WAIT_VB;
`ifdef PALETTE_DMA_QUEUE_EN
        pending <= 1'b0;
`endif
      end
`ifdef PALETTE_DMA_QUEUE_EN
      else if (done && pending) begin
        base_q  <= pending_base;
        rd_idx  <= '0;
        wr_idx  <= '0;
        state   <= brus16_gpu_pkg::WAIT_VB;
        pending <= 1'b0;
      end
`endif
      else if (done) begin
        busy  <= 1'b0;
        state <= brus16_gpu_pkg::IDLE;
      end
`ifdef PALETTE_DMA_QUEUE_EN
      else if (start) begin
        pending      <= 1'b1;
        pending_base <= base_addr;
      end
`endif
    end
  end

endmodule

// File: tb/tb_palette_dma.sv
// Bench for palette_dma: transfer-level reference model plus directed
// scenarios (basic copy, deferred start, stalls, pause, wrap, reset, restart).
module tb_palette_dma;
  import brus16_gpu_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic                vblank = 1'b0;
  logic                busy;
  logic                done;
  pdma_state_t         state;

  palette_dma_if bus();

  palette_dma dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .vblank    (vblank),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- data RAM model ----------------
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom);
  end

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_gnt) bus.mem_rdata <= ram[bus.mem_addr];
    else                            bus.mem_rdata <= DATA_W'($urandom);
  end

  // ---------------- counters and checker ----------------
  int tests_run = 0;
  int fails     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  int gnt_mode = 0;  // 0: always granted, 1: pattern 1,0,0,1, 2: random
  bit vb_rand  = 0;
  int gcnt     = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    gcnt++;
    case (gnt_mode)
      1:       bus.mem_gnt = (gcnt % 4 == 0) || (gcnt % 4 == 3);
      2:       bus.mem_gnt = 1'($urandom_range(0, 1));
      default: bus.mem_gnt = 1'b1;
    endcase
    if (vb_rand) vblank = ($urandom_range(0, 9) != 0);
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] addr);
    start     = 1'b1;
    base_addr = addr;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
    tick();
  endtask

  // ---------------- DUT observation logs ----------------
  int              wr_idx_log[$];
  logic [15:0]     wr_dat_log[$];
  logic [12:0]     rd_addr_log[$];
  int              first_req_cyc = -1;
  int              done_cyc      = -1;
  int              done_cnt      = 0;

  task automatic clear_logs();
    wr_idx_log.delete();
    wr_dat_log.delete();
    rd_addr_log.delete();
    first_req_cyc = -1;
    done_cyc      = -1;
    done_cnt      = 0;
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Model: a transfer is 64 reads of base+k in order while granted and in
  // vblank (not before the cycle after vblank is seen); each read yields one
  // BRAM write the following cycle; done marks the write of entry 63.
  logic [22:0]       exp_q[$];  // {last, idx[5:0], data[15:0]}
  logic              m_busy = 1'b0;
  logic              m_prev_vb = 1'b0;
  logic              m_prev_acc = 1'b0;
  logic [ADDR_W-1:0] m_base = '0;
  int                m_reads = 0;
  logic              m_pend = 1'b0;
  logic [ADDR_W-1:0] m_pbase = '0;

  always @(negedge clk) begin : cmp_blk
    logic              exp_req;
    logic              exp_we;
    logic              exp_done;
    logic              acc;
    logic [22:0]       e;
    logic [ADDR_W-1:0] a;
    if (reset) begin
      chk("rst_mem_req",  bus.mem_req,  0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_pal_cea",  bus.pal_cea,  0);
      chk("rst_pal_ada",  bus.pal_ada,  0);
      chk("rst_pal_din",  bus.pal_din,  0);
      chk("rst_busy",     busy,         0);
      chk("rst_done",     done,         0);
      exp_q.delete();
      m_busy     = 1'b0;
      m_prev_vb  = 1'b0;
      m_prev_acc = 1'b0;
      m_reads    = 0;
      m_pend     = 1'b0;
    end else begin
      a       = m_base + ADDR_W'(m_reads);
      exp_req = m_busy && !m_prev_acc && m_prev_vb && vblank && (m_reads < PAL_ENTRIES);
      chk("mem_req", bus.mem_req, exp_req);
      if (exp_req) chk("mem_addr", bus.mem_addr, a);
      exp_we = (exp_q.size() != 0);
      chk("pal_cea", bus.pal_cea, exp_we);
      exp_done = 1'b0;
      if (exp_we) begin
        e = exp_q.pop_front();
        chk("pal_ada", bus.pal_ada, e[21:16]);
        chk("pal_din", bus.pal_din, e[15:0]);
        exp_done = e[22];
      end
      chk("done", done, exp_done);
      chk("busy", busy, m_busy);

      if (bus.pal_cea) begin
        wr_idx_log.push_back(int'(bus.pal_ada));
        wr_dat_log.push_back(bus.pal_din);
      end
      if (bus.mem_req && bus.mem_gnt) rd_addr_log.push_back(bus.mem_addr);
      if (bus.mem_req && first_req_cyc < 0) first_req_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end

      if (exp_req && bus.mem_gnt) begin
        exp_q.push_back({(m_reads == PAL_ENTRIES - 1), 6'(m_reads), ram[a]});
        m_reads++;
      end
      acc        = start && (!m_busy || exp_done);
      m_prev_acc = acc;
      m_prev_vb  = vblank;
      if (acc) begin
        m_busy  = 1'b1;
        m_base  = base_addr;
        m_reads = 0;
        m_pend  = 1'b0;
      end else if (exp_done && m_pend) begin
        m_base     = m_pbase;
        m_reads    = 0;
        m_pend     = 1'b0;
        m_prev_acc = 1'b1;
      end else if (exp_done) begin
        m_busy = 1'b0;
      end else if (start && m_busy) begin
`ifdef PALETTE_DMA_QUEUE_EN
        m_pend  = 1'b1;
        m_pbase = base_addr;
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int s;
    int v;
    int n;
    bit ok;
    bus.mem_gnt = 1'b1;

    #2 reset = 1'b1;
    repeat (3) tick();
    chk("reset_state", 32'(state), 32'(IDLE));
    reset = 1'b0;
    tick();

    // Basic copy: RAM[0x100+i] = 0xA000+i
    for (int i = 0; i < 64; i++) ram[13'h100 + i] = 16'hA000 + 16'(i);
    vblank = 1'b1;
    clear_logs();
    s = cyc;
    pulse_start(13'h100);
    wait_idle(300);
    chk("basic_latency", 32'(done_cyc - s), 66);
    chk("basic_first_req", 32'(first_req_cyc - s), 2);
    chk("basic_count", wr_idx_log.size(), 64);
    chk("basic_idx0", wr_idx_log[0], 0);
    chk("basic_dat0", wr_dat_log[0], 16'hA000);
    chk("basic_idx63", wr_idx_log[63], 63);
    chk("basic_dat63", wr_dat_log[63], 16'hA03F);

    // Deferred start: outside vblank nothing is read
    vblank = 1'b0;
    clear_logs();
    pulse_start(13'h200);
    repeat (5) tick();
    chk("defer_busy", busy, 1);
    chk("defer_no_req", 32'(first_req_cyc), 32'hFFFF_FFFF);
    vblank = 1'b1;
    v = cyc;
    wait_idle(300);
    chk("defer_first_req", 32'(first_req_cyc - v), 1);
    chk("defer_count", wr_idx_log.size(), 64);

    // Grant stalls 1,0,0,1
    gnt_mode = 1;
    clear_logs();
    pulse_start(13'h300);
    wait_idle(600);
    gnt_mode = 0;
    ok = 1'b1;
    for (int i = 0; i < wr_idx_log.size(); i++) if (wr_idx_log[i] != i) ok = 1'b0;
    chk("stall_count", wr_idx_log.size(), 64);
    chk("stall_order", ok, 1);

    // Vblank pause after 20 reads
    clear_logs();
    pulse_start(13'h400);
    n = 0;
    while (rd_addr_log.size() < 20 && n < 200) begin
      tick();
      n++;
    end
    vblank = 1'b0;
    repeat (8) tick();
    chk("pause_writes", wr_idx_log.size(), 20);
    chk("pause_last_idx", wr_idx_log[19], 19);
    chk("pause_busy", busy, 1);
    vblank = 1'b1;
    wait_idle(300);
    chk("pause_total", wr_idx_log.size(), 64);
    chk("pause_resume_idx", wr_idx_log[20], 20);
    chk("pause_done_once", done_cnt, 1);

    // Address wrap past the top of RAM
    clear_logs();
    pulse_start(13'h1FF0);
    wait_idle(300);
    chk("wrap_addr15", rd_addr_log[15], 13'h1FFF);
    chk("wrap_addr16", rd_addr_log[16], 13'h0000);
    chk("wrap_count", rd_addr_log.size(), 64);

    // Reset mid-transfer
    clear_logs();
    pulse_start(13'h500);
    repeat (30) tick();
    reset = 1'b1;
    #1;
    chk("rstmid_req", bus.mem_req, 0);
    chk("rstmid_cea", bus.pal_cea, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_state", 32'(state), 32'(IDLE));
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Start while busy
    clear_logs();
    pulse_start(13'h600);
    repeat (10) tick();
    pulse_start(13'h700);
    wait_idle(600);
`ifdef PALETTE_DMA_QUEUE_EN
    chk("queue_count", wr_idx_log.size(), 128);
    chk("queue_second_dat", wr_dat_log[64], ram[13'h700]);
    chk("queue_second_addr", rd_addr_log[64], 13'h700);
`else
    chk("ignore_count", wr_idx_log.size(), 64);
    chk("ignore_last_addr", rd_addr_log[63], 13'h63F);
    chk("ignore_done_once", done_cnt, 1);
`endif

    // Randomized traffic: random vblank, grant and start pulses
    vb_rand  = 1;
    gnt_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 40) == 0);
      base_addr = ADDR_W'($urandom);
      tick();
    end
    start    = 1'b0;
    vb_rand  = 0;
    vblank   = 1'b1;
    gnt_mode = 0;
    wait_idle(1000);
    chk("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/palette_dma.md
Name: palette_dma

Overview:
- Copies a 64-entry, 16-bit colour palette from data RAM into the colours BRAM write port on a CPU trigger.
- Transfers run only while `vblank` is high, so the renderer's read port never sees a half-updated palette mid-frame.
- Sits between the CPU's I/O register decode, the data-RAM arbiter (as a secondary requester) and port A of the colours BRAM.
- Port B of the BRAM stays owned by the renderer and is not touched.

Parameters:
- `ADDR_W`, 13, data-RAM word address width.
- `PAL_AW`, 6, palette address width; entry count is 2**PAL_AW = 64.
- `DATA_W`, 16, palette word width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse from the CPU I/O write.
- `base_addr`  in  ADDR_W  source word address; sampled on an accepted `start`.
- `vblank`  in  1  high during vertical blanking; synchronous to `clk`.
- `mem_req`  out  1  request for the data-RAM read port.
- `mem_gnt`  in  1  grant; a read is issued in any cycle with `mem_req && mem_gnt`.
- `mem_addr`  out  ADDR_W  read address; valid while `mem_req` is high.
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after an issued read.
- `pal_cea`  out  1  colours BRAM port-A write enable.
- `pal_ada`  out  PAL_AW  colours BRAM port-A address.
- `pal_din`  out  DATA_W  colours BRAM port-A data.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the 64th write is performed.

Behaviour:
- Reset values:
  - `mem_req`, `pal_cea`, `busy`, `done` = 0.
  - `mem_addr`, `pal_ada`, `pal_din` = 0.
  - State = IDLE, counters = 0.
  - Asserting reset mid-transfer aborts immediately; the BRAM may hold a partial palette.
- State IDLE:
  - `start` latches `base_addr` into `base_q`, clears `rd_idx` (7 bit) and `wr_idx` (7 bit), sets `busy`, and moves to WAIT_VB.
- State WAIT_VB:
  - `mem_req` = 0.
  - Goes to XFER in the cycle after `vblank` is seen high.
- State XFER:
  - `mem_req` = (`rd_idx` < 64) && `vblank`.
  - `mem_addr` = `base_q` + `rd_idx` (modulo 2**ADDR_W; wrap past the top of RAM is allowed).
  - On an issued read: `rd_idx`++; the registered flag `inflight` is set for the next cycle, with `inflight_idx` = `rd_idx`.
  - When `inflight` is set: `pal_cea` = 1, `pal_ada` = `inflight_idx[5:0]`, `pal_din` = `mem_rdata`, and `wr_idx`++.
  - These write-port outputs are combinational from registered state and `mem_rdata`; the write lands in the same cycle the data arrives.
- Stall and pause in XFER:
  - `mem_gnt` low: no read is issued, `rd_idx` holds. An in-flight read still completes its write.
  - `vblank` falls: `mem_req` drops the same cycle and any in-flight write still completes. The FSM then returns to WAIT_VB and resumes at the current `rd_idx` in the next vblank.
- Completion:
  - When `wr_idx` reaches 64: `done` pulses for 1 cycle, `busy` clears, and the FSM returns to IDLE.
  - Minimum latency from `start` (vblank already high, grant always high) to `done`: 66 cycles.
- `start` while `busy`: ignored, unless the optional feature below is enabled.
- `start` in the same cycle as `done`: treated as a new accepted `start`. `busy` stays high and the FSM goes to WAIT_VB.
- `pal_cea` is never asserted outside XFER or the drain cycle that follows a pause.

Optional Feature:
- Macro: `PALETTE_DMA_QUEUE_EN`.
- Defined:
  - A `start` that arrives while `busy` is latched into a one-deep pending slot, holding `pending` and `pending_base`.
  - A later `start` overwrites the slot (last write wins).
  - On `done`, if `pending` is set, the next transfer begins immediately with `base_q` = `pending_base`. `busy` stays high across the two transfers.
- Undefined: `start` while `busy` is dropped with no side effects.

Decomposition:
- Shared package `brus16_gpu_pkg`:
  - Holds `PAL_ENTRIES` = 64, `PAL_AW`, `DATA_W` and `ADDR_W`.
  - Holds the state enum IDLE / WAIT_VB / XFER.
  - Holds the I/O register offset of the palette-DMA trigger.
- Sub-module: none required. The 1-cycle read-to-write alignment stays inline.
- The BRAM wrapper is instantiated at the GPU top level, not inside this block.

Test Plan:
- Basic copy: RAM[0x100+i] = 0xA000+i; `vblank` = 1, `mem_gnt` = 1; `start` with base 0x100 -> 64 writes, `pal_ada` 0..63 with `pal_din` 0xA000..0xA03F; `done` in cycle 66 after `start`.
- Deferred start: `start` while `vblank` = 0 -> `mem_req` stays 0 and `busy` = 1; `vblank` rises -> first read issued 1 cycle later.
- Grant stalls: `mem_gnt` toggles 1,0,0,1 repeating -> every entry still written exactly once and in order; no write while `inflight` = 0.
- Vblank pause: `vblank` drops after 20 reads -> the 20th write still lands, then no activity; at the next vblank writes resume at index 20 and `done` follows the 64th write.
- Wrap and reset: base 0x1FF0 -> `mem_addr` wraps to 0x0000 after 16 reads. Separately, `reset` asserted mid-XFER -> all outputs 0 at once, state IDLE.
- Start while busy: second `start` during a transfer -> ignored without `PALETTE_DMA_QUEUE_EN`; with it, a second 64-entry copy from the new base follows `done` with `busy` held continuously.
